// File: rtl/spi_sfr_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI SFR sequencer: SFR addresses of the SPI master
// core, SPCR bit positions, the sequencer state type and an SPCR builder.
// -----------------------------------------------------------------------------
package spi_pkg;

   // SFR map of the SPI master core
   localparam logic [2:0] SPCR_ADDR  = 3'd0;
   localparam logic [2:0] SPSR_ADDR  = 3'd1;
   localparam logic [2:0] SPDIV_ADDR = 3'd2;
   localparam logic [2:0] SPDR_ADDR  = 3'd3;

   // SPCR bit positions
   localparam int unsigned SPCR_SPE_BIT  = 6;
   localparam int unsigned SPCR_MSTR_BIT = 4;
   localparam int unsigned SPCR_CPOL_BIT = 3;
   localparam int unsigned SPCR_CPHA_BIT = 2;

   typedef enum logic [3:0] {
      IDLE,
      CFG_CTRL,
      CFG_STAT,
      CFG_DIV,
      READY,
      SS_RELEASE,
      SS_ASSERT,
      WR_DATA,
      WAIT_INT,
      RD_DATA,
      RD_CAPTURE,
      CLR_INT,
      PUSH_RX,
      SS_GAP
   } seq_state_e;

   // SPCR = {0, SPE=1, 0, MSTR=1, CPOL, CPHA, 00}
   function automatic logic [7:0] spcr_value(input logic [1:0] mode);
      logic [7:0] v;
      v                = '0;
      v[SPCR_SPE_BIT]  = 1'b1;
      v[SPCR_MSTR_BIT] = 1'b1;
      v[SPCR_CPOL_BIT] = mode[1];
      v[SPCR_CPHA_BIT] = mode[0];
      return v;
   endfunction

endpackage

// File: rtl/spi_sfr_sequencer.sv
// -----------------------------------------------------------------------------
// spi_sfr_sequencer
// Byte-stream front end for the SPI master core. Each transmit byte is run
// through the core's SFR port: slave select, SPDR write, wait for intspi,
// SPDR read, SPSR clear; the received byte is returned on the rx stream.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_start/mode/div/ss      (re)configuration request and values
//   tx_valid/ready/data/last   transmit byte stream
//   rx_valid/ready/data        receive byte stream
//   sfraddr_w/sfrwe/sfrdata_o  core SFR write port (sfrdata_o -> spidata_i)
//   sfraddr_r/sfrdata_i        core SFR read port (sfrdata_i <- sfrdatao)
//   intspi                     core transfer-complete flag
//   spssn                      active-low one-hot slave selects
//   busy                       high outside IDLE and READY
//   err_timeout                sticky intspi timeout flag, cleared by cfg_start
//
// Build option: SPI_SEQ_TIMEOUT_EN enables the intspi wait timeout
// (TIMEOUT_CYCLES); without it WAIT_INT waits indefinitely and err_timeout
// stays 0.
// -----------------------------------------------------------------------------
module spi_sfr_sequencer
   import spi_pkg::*;
#(
   parameter int unsigned SS_GAP_CYCLES  = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cfg_start,
   input  logic [1:0] cfg_mode,
   input  logic [7:0] cfg_div,
   input  logic [2:0] cfg_ss,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic [2:0] sfraddr_w,
   output logic [2:0] sfraddr_r,
   output logic       sfrwe,
   output logic [7:0] sfrdata_o,
   input  logic [7:0] sfrdata_i,
   input  logic       intspi,
   output logic [7:0] spssn,
   output logic       busy,
   output logic       err_timeout
);

   seq_state_e  state;
   logic [1:0]  mode_q;
   logic [7:0]  div_q;
   logic [2:0]  ss_q;
   logic [7:0]  tx_byte;
   logic        tx_last_q;
   logic [15:0] gap_cnt;
`ifdef SPI_SEQ_TIMEOUT_EN
   logic [15:0] to_cnt;
`endif

   // All outputs are registered: each transition drives the values that
   // belong to the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         mode_q      <= '0;
         div_q       <= '0;
         ss_q        <= '0;
         tx_byte     <= '0;
         tx_last_q   <= 1'b0;
         gap_cnt     <= '0;
         spssn       <= '1;
         sfrwe       <= 1'b0;
         sfraddr_w   <= '0;
         sfraddr_r   <= '0;
         sfrdata_o   <= '0;
         tx_ready    <= 1'b0;
         rx_valid    <= 1'b0;
         rx_data     <= '0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
         to_cnt      <= '0;
`endif
      end else begin
         sfrwe     <= 1'b0;
         sfraddr_w <= '0;
         sfraddr_r <= '0;
         unique case (state)
            IDLE: begin
               if (cfg_start) begin
                  mode_q      <= cfg_mode;
                  div_q       <= cfg_div;
                  ss_q        <= cfg_ss;
                  err_timeout <= 1'b0;
                  sfrwe       <= 1'b1;
                  sfraddr_w   <= SPCR_ADDR;
                  sfrdata_o   <= spcr_value(cfg_mode);
                  busy        <= 1'b1;
                  state       <= CFG_CTRL;
               end
            end
            CFG_CTRL: begin
               sfrwe     <= 1'b1;
               sfraddr_w <= SPSR_ADDR;
               sfrdata_o <= 8'h01;
               state     <= CFG_STAT;
            end
            CFG_STAT: begin
               sfrwe     <= 1'b1;
               sfraddr_w <= SPDIV_ADDR;
               sfrdata_o <= div_q;
               state     <= CFG_DIV;
            end
            CFG_DIV: begin
               tx_ready <= 1'b1;
               busy     <= 1'b0;
               state    <= READY;
            end
            READY: begin
               // tx_ready is high here, so tx_valid alone is the handshake;
               // an accepted byte wins over a coincident cfg_start.
               if (tx_valid) begin
                  tx_byte   <= tx_data;
                  tx_last_q <= tx_last;
                  spssn     <= ~(8'd1 << ss_q);
                  tx_ready  <= 1'b0;
                  busy      <= 1'b1;
                  state     <= SS_ASSERT;
               end else if (cfg_start) begin
                  mode_q      <= cfg_mode;
                  div_q       <= cfg_div;
                  ss_q        <= cfg_ss;
                  err_timeout <= 1'b0;
                  tx_ready    <= 1'b0;
                  busy        <= 1'b1;
                  if (spssn != '1) begin
                     // open frame: drop the select for a cycle before the
                     // core is reprogrammed
                     spssn <= '1;
                     state <= SS_RELEASE;
                  end else begin
                     sfrwe     <= 1'b1;
                     sfraddr_w <= SPCR_ADDR;
                     sfrdata_o <= spcr_value(cfg_mode);
                     state     <= CFG_CTRL;
                  end
               end
            end
            SS_RELEASE: begin
               sfrwe     <= 1'b1;
               sfraddr_w <= SPCR_ADDR;
               sfrdata_o <= spcr_value(mode_q);
               state     <= CFG_CTRL;
            end
            SS_ASSERT: begin
               sfrwe     <= 1'b1;
               sfraddr_w <= SPDR_ADDR;
               sfrdata_o <= tx_byte;
               state     <= WR_DATA;
            end
            WR_DATA: begin
`ifdef SPI_SEQ_TIMEOUT_EN
               to_cnt <= '0;
`endif
               state  <= WAIT_INT;
            end
            WAIT_INT: begin
               if (intspi) begin
                  sfraddr_r <= SPDR_ADDR;
                  state     <= RD_DATA;
               end
`ifdef SPI_SEQ_TIMEOUT_EN
               else if (to_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                  err_timeout <= 1'b1;
                  spssn       <= '1;
                  tx_ready    <= 1'b1;
                  busy        <= 1'b0;
                  state       <= READY;
               end else begin
                  to_cnt <= to_cnt + 16'd1;
               end
`endif
            end
            RD_DATA: begin
               rx_data <= sfrdata_i;
               state   <= RD_CAPTURE;
            end
            RD_CAPTURE: begin
               sfrwe     <= 1'b1;
               sfraddr_w <= SPSR_ADDR;
               sfrdata_o <= 8'h00;
               state     <= CLR_INT;
            end
            CLR_INT: begin
               rx_valid <= 1'b1;
               state    <= PUSH_RX;
            end
            PUSH_RX: begin
               if (rx_ready) begin
                  rx_valid <= 1'b0;
                  if (tx_last_q) begin
                     spssn   <= '1;
                     gap_cnt <= '0;
                     state   <= SS_GAP;
                  end else begin
                     tx_ready <= 1'b1;
                     busy     <= 1'b0;
                     state    <= READY;
                  end
               end
            end
            SS_GAP: begin
               if (gap_cnt == 16'(SS_GAP_CYCLES - 1)) begin
                  tx_ready <= 1'b1;
                  busy     <= 1'b0;
                  state    <= READY;
               end else begin
                  gap_cnt <= gap_cnt + 16'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_sfr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_sfr_sequencer
// Directed bench for spi_sfr_sequencer with a small SPI core model: an SPDR
// write raises intspi after a programmable delay, an SPSR write of 0 clears
// it, and an SPDR read returns the programmed slave reply.
// -----------------------------------------------------------------------------
module tb_spi_sfr_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_start;
   logic [1:0] cfg_mode;
   logic [7:0] cfg_div;
   logic [2:0] cfg_ss;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic [2:0] sfraddr_w;
   logic [2:0] sfraddr_r;
   logic       sfrwe;
   logic [7:0] sfrdata_o;
   logic [7:0] sfrdata_i;
   logic       intspi;
   logic [7:0] spssn;
   logic       busy;
   logic       err_timeout;

   int n_checks = 0;
   int n_bad    = 0;

   // core model controls
   logic [7:0]  slave_reply;
   int unsigned int_delay;
   logic        int_en;
   int unsigned int_cnt;
   logic        int_pend;

   always #5 clk = ~clk;

   spi_sfr_sequencer #(
      .SS_GAP_CYCLES (8),
      .TIMEOUT_CYCLES(1024)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_start  (cfg_start),
      .cfg_mode   (cfg_mode),
      .cfg_div    (cfg_div),
      .cfg_ss     (cfg_ss),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_data    (tx_data),
      .tx_last    (tx_last),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .rx_data    (rx_data),
      .sfraddr_w  (sfraddr_w),
      .sfraddr_r  (sfraddr_r),
      .sfrwe      (sfrwe),
      .sfrdata_o  (sfrdata_o),
      .sfrdata_i  (sfrdata_i),
      .intspi     (intspi),
      .spssn      (spssn),
      .busy       (busy),
      .err_timeout(err_timeout)
   );

   assign sfrdata_i = (sfraddr_r == 3'd3) ? slave_reply : 8'h00;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         intspi   <= 1'b0;
         int_pend <= 1'b0;
         int_cnt  <= 0;
      end else begin
         if (sfrwe && sfraddr_w == 3'd3) begin
            int_pend <= int_en;
            int_cnt  <= int_delay;
         end else if (int_pend) begin
            if (int_cnt == 0) begin
               intspi   <= 1'b1;
               int_pend <= 1'b0;
            end else begin
               int_cnt <= int_cnt - 1;
            end
         end
         if (sfrwe && sfraddr_w == 3'd1 && sfrdata_o == 8'h00) intspi <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals();
      check("rst_spssn",    spssn,       8'hFF);
      check("rst_sfrwe",    sfrwe,       0);
      check("rst_addr_w",   sfraddr_w,   0);
      check("rst_addr_r",   sfraddr_r,   0);
      check("rst_data_o",   sfrdata_o,   0);
      check("rst_tx_ready", tx_ready,    0);
      check("rst_rx_valid", rx_valid,    0);
      check("rst_rx_data",  rx_data,     0);
      check("rst_busy",     busy,        0);
      check("rst_err",      err_timeout, 0);
   endtask

   task automatic wait_tx_ready();
      for (int i = 0; i < 50 && !tx_ready; i++) tick();
      check("tx_ready_wait", tx_ready, 1);
   endtask

   task automatic do_config(input logic [1:0] m, input logic [7:0] dv, input logic [2:0] s,
                            input logic [7:0] exp_spcr, input logic release_first);
      cfg_mode  = m;
      cfg_div   = dv;
      cfg_ss    = s;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      if (release_first) begin
         check("rel_spssn", spssn, 8'hFF);
         check("rel_we",    sfrwe, 0);
         check("rel_busy",  busy,  1);
         tick();
      end
      check("cfg_spcr_we",   sfrwe,     1);
      check("cfg_spcr_addr", sfraddr_w, 0);
      check("cfg_spcr_data", sfrdata_o, exp_spcr);
      check("cfg_busy",      busy,      1);
      check("cfg_tx_ready",  tx_ready,  0);
      tick();
      check("cfg_spsr_we",   sfrwe,     1);
      check("cfg_spsr_addr", sfraddr_w, 1);
      check("cfg_spsr_data", sfrdata_o, 8'h01);
      tick();
      check("cfg_div_we",    sfrwe,     1);
      check("cfg_div_addr",  sfraddr_w, 2);
      check("cfg_div_data",  sfrdata_o, dv);
      tick();
      check("cfg_done_txr",  tx_ready,  1);
      check("cfg_done_busy", busy,      0);
      check("cfg_done_we",   sfrwe,     0);
      check("cfg_done_err",  err_timeout, 0);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last, input logic [7:0] reply,
                            input logic [7:0] exp_ss, input int unsigned hold);
      int unsigned n;
      slave_reply = reply;
      wait_tx_ready();
      tx_data  = d;
      tx_last  = last;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      check("ss_assert",   spssn,    exp_ss);
      check("frame_busy",  busy,     1);
      check("frame_txr",   tx_ready, 0);
      tick();
      check("wr_we",   sfrwe,     1);
      check("wr_addr", sfraddr_w, 3);
      check("wr_data", sfrdata_o, d);
      n = 0;
      while (!intspi && n < 2000) begin
         tick();
         n++;
      end
      check("intspi_wait", intspi, 1);
      check("ss_in_wait",  spssn,  exp_ss);
      tick();
      check("rd_addr",     sfraddr_r, 3);
      check("rxv_early1",  rx_valid,  0);
      tick();
      check("rxv_early2",  rx_valid,  0);
      tick();
      check("clr_we",      sfrwe,     1);
      check("clr_addr",    sfraddr_w, 1);
      check("clr_data",    sfrdata_o, 0);
      check("rxv_early3",  rx_valid,  0);
      tick();
      check("rx_valid",    rx_valid,  1);
      check("rx_data",     rx_data,   reply);
      for (int unsigned i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", rx_valid, 1);
         check("hold_data",  rx_data,  reply);
         check("hold_txr",   tx_ready, 0);
      end
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      check("rx_pop", rx_valid, 0);
      if (last) begin
         check("ss_gap_start", spssn, 8'hFF);
      end else begin
         check("ss_kept",       spssn,    exp_ss);
         check("tx_ready_next", tx_ready, 1);
      end
   endtask

   task automatic check_gap();
      for (int i = 0; i < 8; i++) begin
         check("gap_spssn", spssn,    8'hFF);
         check("gap_txr",   tx_ready, 0);
         check("gap_rxv",   rx_valid, 0);
         tick();
      end
      check("gap_end_txr", tx_ready, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned n;
      rst_n       = 1'b0;
      cfg_start   = 1'b0;
      cfg_mode    = '0;
      cfg_div     = '0;
      cfg_ss      = '0;
      tx_valid    = 1'b0;
      tx_data     = '0;
      tx_last     = 1'b0;
      rx_ready    = 1'b0;
      slave_reply = '0;
      int_delay   = 2;
      int_en      = 1'b1;
      repeat (3) tick();
      check_reset_vals();
      rst_n = 1'b1;
      repeat (2) tick();
      check("idle_txr", tx_ready, 0);

      // configuration: mode 00, div 0, ss 0 -> SPCR 0x50
      do_config(2'b00, 8'h00, 3'd0, 8'h50, 1'b0);

      // single-byte frame, loopback reply 0x3C
      send_byte(8'hA5, 1'b1, 8'h3C, 8'hFE, 0);
      check_gap();

      // 3-byte frame, second beat held off for 20 cycles
      send_byte(8'h11, 1'b0, 8'hEE, 8'hFE, 0);
      check("between_ss", spssn, 8'hFE);
      send_byte(8'h22, 1'b0, 8'hDD, 8'hFE, 20);
      check("between_ss", spssn, 8'hFE);
      send_byte(8'h33, 1'b1, 8'hCC, 8'hFE, 0);
      check_gap();

      // slow intspi, open frame left behind
      int_delay = 40;
      send_byte(8'h5A, 1'b0, 8'h77, 8'hFE, 0);
      check("slow_no_err", err_timeout, 0);
      int_delay = 2;

      // reconfigure with the select still asserted: mode 11 -> SPCR 0x5C
      do_config(2'b11, 8'h12, 3'd3, 8'h5C, 1'b1);
      send_byte(8'h0F, 1'b1, 8'hF0, 8'hF7, 0);
      check_gap();

`ifdef SPI_SEQ_TIMEOUT_EN
      // intspi never arrives
      int_en = 1'b0;
      wait_tx_ready();
      tx_data  = 8'h42;
      tx_last  = 1'b0;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      n = 0;
      while (!err_timeout && n < 1100) begin
         tick();
         n++;
      end
      check("to_err",    err_timeout, 1);
      check("to_cycles", n,           1026);
      check("to_spssn",  spssn,       8'hFF);
      check("to_rxv",    rx_valid,    0);
      check("to_txr",    tx_ready,    1);
      check("to_busy",   busy,        0);
      do_config(2'b11, 8'h12, 3'd3, 8'h5C, 1'b0);
      int_en = 1'b1;
`endif

      // asynchronous reset while waiting for intspi
      int_en = 1'b0;
      wait_tx_ready();
      tx_data  = 8'h99;
      tx_last  = 1'b0;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      repeat (4) tick();
      check("wait_busy",  busy,  1);
      check("wait_spssn", spssn, 8'hF7);
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      tick();
      rst_n    = 1'b1;
      tx_valid = 1'b1;
      repeat (3) tick();
      check("post_rst_txr",   tx_ready, 0);
      check("post_rst_busy",  busy,     0);
      check("post_rst_spssn", spssn,    8'hFF);
      tx_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
